// File: rtl/riscv_irq_arbiter_pkg.sv
// Shared types and helpers for the interrupt arbiter: privilege levels,
// handshake FSM states and the per-line global-enable rule.
package riscv_irq_arbiter_pkg;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_H = 2'b10,
        PRIV_LVL_M = 2'b11
    } PrivLvl_t;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'b00,
        IRQ_PENDING = 2'b01,
        IRQ_DONE    = 2'b10
    } irq_state_e;

    // A delegated line may interrupt only below M; a non-delegated line
    // always interrupts below M and needs MIE when already in M.
    function automatic logic irq_line_enable(
        input logic     secure,
        input logic     deleg,
        input PrivLvl_t priv,
        input logic     m_ie,
        input logic     s_ie
    );
        logic en;
        if (!secure) begin
            en = m_ie;
        end else if (deleg) begin
            en = (priv == PRIV_LVL_U) || ((priv == PRIV_LVL_S) && s_ie);
        end else begin
            en = (priv != PRIV_LVL_M) || m_ie;
        end
        return en;
    endfunction

    function automatic PrivLvl_t irq_target_priv(
        input logic secure,
        input logic deleg
    );
        return (secure && deleg) ? PRIV_LVL_S : PRIV_LVL_M;
    endfunction

endpackage

// File: rtl/riscv_irq_arbiter_if.sv
// Request/acknowledge handshake between the interrupt arbiter (master)
// and the core controller (slave).
interface riscv_irq_arbiter_if #(
    parameter int ID_W = 5
);
    import riscv_irq_arbiter_pkg::*;

    logic            irq_req_ctrl;
    logic [ID_W-1:0] irq_id_ctrl;
    logic            irq_sec_ctrl;
    PrivLvl_t        irq_priv;
    logic            ctrl_ack;
    logic            ctrl_kill;

    modport master (
        output irq_req_ctrl,
        output irq_id_ctrl,
        output irq_sec_ctrl,
        output irq_priv,
        input  ctrl_ack,
        input  ctrl_kill
    );

    modport slave (
        input  irq_req_ctrl,
        input  irq_id_ctrl,
        input  irq_sec_ctrl,
        input  irq_priv,
        output ctrl_ack,
        output ctrl_kill
    );

endinterface

// File: rtl/riscv_irq_prio_enc.sv
// Fixed-priority encoder: reports whether any bit is set and the index of
// the highest set bit.
module riscv_irq_prio_enc #(
    parameter int NUM_IRQ = 32,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] vec_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    id_o
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        valid_o = |vec_i;
        id_o    = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (vec_i[i]) begin
                id_o = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/riscv_irq_arbiter.sv
// N-line interrupt controller: captures level/edge lines, applies local and
// global enables, picks the highest eligible line and hands it to the core.
module riscv_irq_arbiter
    import riscv_irq_arbiter_pkg::*;
#(
    parameter int                 NUM_IRQ      = 32,
    parameter int                 ID_W         = $clog2(NUM_IRQ),
    parameter logic [NUM_IRQ-1:0] EDGE_MASK    = '0,
    parameter bit                 RISCV_SECURE = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_IRQ-1:0]         irq_i,
    input  logic [NUM_IRQ-1:0]         irq_sec_i,
    input  logic [NUM_IRQ-1:0]         mie_i,
    input  logic [NUM_IRQ-1:0]         mideleg_i,
    input  logic                       m_IE_i,
    input  logic                       s_IE_i,
    input  PrivLvl_t                   current_priv_lvl_i,
    input  logic                       debug_mode_i,
    riscv_irq_arbiter_if.master        ctrl_if,
    output logic [NUM_IRQ-1:0]         irq_pending_o
);

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] edge_set, edge_clr;
    logic [NUM_IRQ-1:0] gen_en;
    logic [NUM_IRQ-1:0] eligible;
    logic               win_valid;
    logic [ID_W-1:0]    win_id;

    irq_state_e         state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               sec_q, sec_d;
    PrivLvl_t           priv_q, priv_d;
    logic               ack_accept;

    assign ack_accept = (state_q == IRQ_PENDING) && ctrl_if.ctrl_ack;

    // Edge lines stay pending until their own ack; a new edge in the ack
    // cycle wins over the clear so that it is not lost.
    always_comb begin
        edge_set = irq_i & ~irq_q;
        edge_clr = '0;
        if (ack_accept) begin
            edge_clr[id_q] = 1'b1;
        end
        pend_d = (EDGE_MASK & (edge_set | (pend_q & ~edge_clr)))
               | (~EDGE_MASK & irq_i);
    end

    always_comb begin
        gen_en = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            gen_en[i] = irq_line_enable(RISCV_SECURE, mideleg_i[i],
                                        current_priv_lvl_i, m_IE_i, s_IE_i);
        end
    end

    assign eligible = pend_q & mie_i & gen_en;

    riscv_irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_prio_enc (
        .vec_i   (eligible),
        .valid_o (win_valid),
        .id_o    (win_id)
    );

    // Request fields are latched only in IDLE, so they stay stable for the
    // whole PENDING phase regardless of line or enable changes.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        sec_d   = sec_q;
        priv_d  = priv_q;
        case (state_q)
            IRQ_IDLE: begin
                if (win_valid && !debug_mode_i) begin
                    state_d = IRQ_PENDING;
                    id_d    = win_id;
                    sec_d   = irq_sec_i[win_id];
                    priv_d  = irq_target_priv(RISCV_SECURE, mideleg_i[win_id]);
                end
            end
            IRQ_PENDING: begin
                if (ctrl_if.ctrl_ack) begin
                    state_d = IRQ_DONE;
                end else if (ctrl_if.ctrl_kill) begin
                    state_d = IRQ_IDLE;
                end
            end
            IRQ_DONE: begin
                state_d = IRQ_IDLE;
                sec_d   = 1'b0;
            end
            default: begin
                state_d = IRQ_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q   <= '0;
            pend_q  <= '0;
            state_q <= IRQ_IDLE;
            id_q    <= '0;
            sec_q   <= 1'b0;
            priv_q  <= PRIV_LVL_M;
        end else begin
            irq_q   <= irq_i;
            pend_q  <= pend_d;
            state_q <= state_d;
            id_q    <= id_d;
            sec_q   <= sec_d;
            priv_q  <= priv_d;
        end
    end

    assign ctrl_if.irq_req_ctrl = (state_q == IRQ_PENDING);
    assign ctrl_if.irq_id_ctrl  = id_q;
    assign ctrl_if.irq_sec_ctrl = sec_q;
    assign ctrl_if.irq_priv     = priv_q;
    assign irq_pending_o        = pend_q;

endmodule
